// File: rtl/source_injection_arbiter.sv
// Round-robin burst arbiter that funnels NSRC traffic sources into one
// router injection port through a single registered output slot.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module source_injection_arbiter #(
   parameter int NSRC      = 4,
   parameter int MAX_BURST = 4,
   parameter int HOLD      = 2,
   parameter int W         = `PAYLOAD_SIZE + `ADDR_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NSRC*W-1:0] src_item,
   input  logic [NSRC-1:0]   src_valid,
   output logic [NSRC-1:0]   src_send,
   output logic [NSRC-1:0]   src_busy,
   output logic [W-1:0]      item_out,
   output logic              valid_out,
   input  logic              busy_in,
   output logic [15:0]       tx_count
);

   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]    burst_cnt_q, burst_cnt_d;
   logic [2:0]    idle_cnt_q, idle_cnt_d;
   logic [W-1:0]  item_q, item_d;
   logic          valid_q, valid_d;
   logic [15:0]   tx_q, tx_d;

   logic          granted;
   logic          accept_ok;
   logic          owner_valid;
   logic          accept;
   logic          consume;
   logic          burst_done;
   logic          hold_done;
   logic [PW-1:0] owner_nxt;
   logic [PW-1:0] pick;
   logic [PW-1:0] idx;
   logic          found;
   logic [W-1:0]  owner_item;

   assign granted     = (state_q == GRANT);
   assign accept_ok   = !valid_q || !busy_in;
   assign owner_valid = src_valid[owner_q];
   assign accept      = granted && owner_valid && accept_ok;
   assign consume     = valid_q && !busy_in;
   assign burst_done  = accept &&
                        (burst_cnt_q == 4'(MAX_BURST - 1));
   assign hold_done   = granted && !owner_valid &&
                        (idle_cnt_q == 3'(HOLD - 1));
   assign owner_nxt   = (owner_q == PW'(NSRC - 1)) ?
                        '0 : owner_q + 1'b1;

   // first requester at or after rr_ptr, wrapping modulo NSRC
   always_comb begin
      pick  = rr_ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NSRC; k++) begin
         idx = PW'((int'(rr_ptr_q) + k) % NSRC);
         if (!found && src_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      owner_item = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (owner_q == PW'(i)) owner_item = src_item[i*W +: W];
      end
   end

   always_comb begin
      src_send = '0;
      src_busy = '1;
      for (int i = 0; i < NSRC; i++) begin
         if (granted && owner_q == PW'(i)) begin
            src_send[i] = 1'b1;
            src_busy[i] = !accept_ok;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      item_d      = item_q;
      valid_d     = valid_q;
      tx_d        = tx_q;
      if (consume) begin
         valid_d = 1'b0;
         tx_d    = tx_q + 16'd1;
      end
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = GRANT;
               owner_d     = pick;
               burst_cnt_d = '0;
               idle_cnt_d  = '0;
            end
         end
         GRANT: begin
            if (accept) begin
               item_d      = owner_item;
               valid_d     = 1'b1;
               burst_cnt_d = burst_cnt_q + 4'd1;
               idle_cnt_d  = '0;
            end else if (!owner_valid) begin
               idle_cnt_d = idle_cnt_q + 3'd1;
            end
            if (burst_done || hold_done) begin
               state_d  = IDLE;
               rr_ptr_d = owner_nxt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         idle_cnt_q  <= '0;
         item_q      <= '0;
         valid_q     <= 1'b0;
         tx_q        <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         item_q      <= item_d;
         valid_q     <= valid_d;
         tx_q        <= tx_d;
      end
   end

   assign item_out  = item_q;
   assign valid_out = valid_q;
   assign tx_count  = tx_q;

endmodule
